// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO read-side stream consumer.
package fifo_stream_pkg;
    localparam int UF_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;
endpackage

// File: rtl/stream_skid_buf.sv
// Small circular register buffer that absorbs FIFO read latency so pops never
// depend combinationally on downstream ready.
module stream_skid_buf #(
    parameter int DATA_WIDTH = 2,
    parameter int DEPTH      = 3,
    parameter int OCC_W      = 2
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [OCC_W-1:0]      occ
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  pop_ok;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_ok = pop && (occ != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop_ok) rd_ptr <= bump(rd_ptr);
            case ({push, pop_ok})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO consumer: primes to a fill level, then streams FIFO words out
// over valid/ready, counting underflows.
//
//   state   | meaning
//   IDLE    | disabled, no pops
//   FILL    | waiting for water level to reach START_LEVEL
//   STREAM  | popping while skid buffer has room
//   DRAIN   | no new pops; emptying in-flight and buffered words
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 2,
    parameter int ADDR_WIDTH  = 4,
    parameter int START_LEVEL = 8,
    parameter int RD_LATENCY  = 1
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH:0]   fifo_rd_water_level,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  underflow,
    output logic [UF_CNT_W-1:0]   underflow_cnt,
    output logic [1:0]            state
);
    localparam int DEPTH = RD_LATENCY + 2;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int LVL_W = ADDR_WIDTH + 1;
    localparam logic [OCC_W:0]   DEPTH_V = (OCC_W + 1)'(DEPTH);
    localparam logic [LVL_W-1:0] START_V = LVL_W'(START_LEVEL);

    state_t              st;
    state_t              st_nxt;
    logic [OCC_W-1:0]    occ;
    logic [OCC_W-1:0]    infl;
    logic [OCC_W:0]      pending;
    logic                capture;
    logic                uf_hit;
    logic                uf_q;
    logic [UF_CNT_W-1:0] uf_cnt;

    generate
        if (RD_LATENCY == 0) begin : g_lat0
            assign infl    = '0;
            assign capture = fifo_rd_en;
        end else begin : g_lat1
            logic pop_d;
            always_ff @(posedge rd_clk or negedge rd_rst_n) begin
                if (!rd_rst_n) pop_d <= 1'b0;
                else           pop_d <= fifo_rd_en;
            end
            assign infl    = OCC_W'(pop_d);
            assign capture = pop_d;
        end
    endgenerate

    stream_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .OCC_W     (OCC_W)
    ) u_skid (
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .push     (capture),
        .push_data(fifo_rd_data),
        .pop      (m_valid & m_ready),
        .head     (m_data),
        .occ      (occ)
    );

    assign pending = {1'b0, occ} + {1'b0, infl};
    assign uf_hit  = (st == ST_STREAM) && (occ == '0) && (infl == '0) && fifo_empty;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) st <= ST_IDLE;
        else           st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE:   if (enable) st_nxt = ST_FILL;
            ST_FILL:   if (!enable) st_nxt = ST_IDLE;
                       else if (fifo_rd_water_level >= START_V) st_nxt = ST_STREAM;
            // Underflow wins over a simultaneous disable.
            ST_STREAM: if (uf_hit) st_nxt = ST_FILL;
                       else if (!enable) st_nxt = ST_DRAIN;
            ST_DRAIN:  if ((occ == '0) && (infl == '0)) st_nxt = ST_IDLE;
            default:   st_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        state      = st;
        m_valid    = (occ != '0);
        fifo_rd_en = (st == ST_STREAM) && !fifo_empty && (pending < DEPTH_V);
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            uf_q   <= 1'b0;
            uf_cnt <= '0;
        end else begin
            uf_q <= uf_hit;
            if (uf_hit && (uf_cnt != '1)) uf_cnt <= uf_cnt + UF_CNT_W'(1);
        end
    end

    assign underflow     = uf_q;
    assign underflow_cnt = uf_cnt;
endmodule
